// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues one registered data-memory request per aligned load/store,
// stalls upstream until the response (or a 15-cycle timeout), resolves branches, and
// owns the MEM/WB pipeline register.
//
// Ports
//   clk_i, rst_i                 clock; synchronous active-high reset
//   alu_c_i, rt_data_i, npc_i    EX/MEM address/ALU result, store data, branch target
//   reg_rd_i, memr_i, memw_i,    EX/MEM control fields
//   regw_i, mem2r_i, zero_i,
//   branch_i
//   dm_req_o, dm_we_o,           registered data-memory request
//   dm_addr_o, dm_wdata_o
//   dm_rdata_i, dm_ack_i         memory response (rdata valid only with ack)
//   stall_o                      holds EX/MEM and upstream stages
//   pc_src_o, flush_o            branch redirect select and pipeline flush
//   wb_rdata_o, wb_alu_o,        MEM/WB register
//   wb_rd_o, wb_regw_o,
//   wb_mem2r_o
//   align_err_o, bus_err_o       sticky error flags, cleared only by reset
module mem_access_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] alu_c_i,
   input  logic [31:0] rt_data_i,
   input  logic [31:0] npc_i,
   input  logic [4:0]  reg_rd_i,
   input  logic        memr_i,
   input  logic        memw_i,
   input  logic        regw_i,
   input  logic        mem2r_i,
   input  logic        zero_i,
   input  logic [1:0]  branch_i,
   output logic        dm_req_o,
   output logic        dm_we_o,
   output logic [31:0] dm_addr_o,
   output logic [31:0] dm_wdata_o,
   input  logic [31:0] dm_rdata_i,
   input  logic        dm_ack_i,
   output logic        stall_o,
   output logic        pc_src_o,
   output logic        flush_o,
   output logic [31:0] wb_rdata_o,
   output logic [31:0] wb_alu_o,
   output logic [4:0]  wb_rd_o,
   output logic        wb_regw_o,
   output logic        wb_mem2r_o,
   output logic        align_err_o,
   output logic        bus_err_o
);

   typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

   state_e      state_q, state_d;
   logic [3:0]  tmo_q, tmo_d;
   logic [31:0] cap_q, cap_d;
   logic        dm_req_q, dm_req_d, dm_we_q, dm_we_d;
   logic [31:0] dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
   logic [31:0] wb_rdata_q, wb_rdata_d, wb_alu_q, wb_alu_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic        wb_regw_q, wb_regw_d, wb_mem2r_q, wb_mem2r_d;
   logic        align_err_q, align_err_d, bus_err_q, bus_err_d;

   logic mem_op, access, misaligned, stall, taken, timeout;

   // The branch target is consumed by the fetch stage; only pc_src is produced here.
   logic unused_npc;
   assign unused_npc = ^npc_i;

   assign mem_op     = memr_i | memw_i;
   assign access     = mem_op & (alu_c_i[1:0] == 2'b00);
   assign misaligned = mem_op & (alu_c_i[1:0] != 2'b00);
   assign stall      = ((state_q == StIdle) & access) | (state_q == StReq);
   // tmo_q counts REQ cycles already spent without ack; the 15th such cycle gives up.
   assign timeout    = (state_q == StReq) & ~dm_ack_i & (tmo_q == 4'd14);
   assign taken      = ((branch_i == 2'b01) & zero_i) | ((branch_i == 2'b10) & ~zero_i) |
                       (branch_i == 2'b11);

   always_comb begin
      state_d     = state_q;
      tmo_d       = tmo_q;
      cap_d       = cap_q;
      dm_req_d    = dm_req_q;
      dm_we_d     = dm_we_q;
      dm_addr_d   = dm_addr_q;
      dm_wdata_d  = dm_wdata_q;
      align_err_d = align_err_q;
      bus_err_d   = bus_err_q;

      unique case (state_q)
         StIdle: begin
            if (access) begin
               state_d    = StReq;
               tmo_d      = 4'd0;
               dm_req_d   = 1'b1;
               dm_we_d    = memw_i;
               dm_addr_d  = alu_c_i;
               dm_wdata_d = rt_data_i;
            end
            if (misaligned) align_err_d = 1'b1;
         end
         StReq: begin
            if (dm_ack_i || timeout) begin
               state_d  = StDone;
               dm_req_d = 1'b0;
               dm_we_d  = 1'b0;
            end
            if (dm_ack_i) begin
               cap_d = memr_i ? dm_rdata_i : 32'd0;
            end else begin
               tmo_d = tmo_q + 4'd1;
               if (timeout) begin
                  cap_d     = 32'd0;
                  bus_err_d = 1'b1;
               end
            end
         end
         // The held instruction advances out of MEM here without re-issuing.
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (stall) begin
         // Bubble: writeback suppressed, data fields keep their last values.
         wb_rd_d    = wb_rd_q;
         wb_alu_d   = wb_alu_q;
         wb_rdata_d = wb_rdata_q;
         wb_regw_d  = 1'b0;
         wb_mem2r_d = 1'b0;
      end else begin
         wb_rd_d    = reg_rd_i;
         wb_alu_d   = alu_c_i;
         wb_rdata_d = cap_q;
         wb_regw_d  = regw_i & ~misaligned;
         wb_mem2r_d = mem2r_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         tmo_q       <= 4'd0;
         cap_q       <= 32'd0;
         dm_req_q    <= 1'b0;
         dm_we_q     <= 1'b0;
         dm_addr_q   <= 32'd0;
         dm_wdata_q  <= 32'd0;
         wb_rdata_q  <= 32'd0;
         wb_alu_q    <= 32'd0;
         wb_rd_q     <= 5'd0;
         wb_regw_q   <= 1'b0;
         wb_mem2r_q  <= 1'b0;
         align_err_q <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         cap_q       <= cap_d;
         dm_req_q    <= dm_req_d;
         dm_we_q     <= dm_we_d;
         dm_addr_q   <= dm_addr_d;
         dm_wdata_q  <= dm_wdata_d;
         wb_rdata_q  <= wb_rdata_d;
         wb_alu_q    <= wb_alu_d;
         wb_rd_q     <= wb_rd_d;
         wb_regw_q   <= wb_regw_d;
         wb_mem2r_q  <= wb_mem2r_d;
         align_err_q <= align_err_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign dm_req_o    = dm_req_q;
   assign dm_we_o     = dm_we_q;
   assign dm_addr_o   = dm_addr_q;
   assign dm_wdata_o  = dm_wdata_q;
   assign stall_o     = stall;
   assign pc_src_o    = taken & ~stall;
   assign flush_o     = taken & ~stall;
   assign wb_rdata_o  = wb_rdata_q;
   assign wb_alu_o    = wb_alu_q;
   assign wb_rd_o     = wb_rd_q;
   assign wb_regw_o   = wb_regw_q;
   assign wb_mem2r_o  = wb_mem2r_q;
   assign align_err_o = align_err_q;
   assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios followed by randomized instructions,
// checked against a transaction-level model of the MEM stage.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] alu_c, rt_data, npc, dm_addr, dm_wdata, dm_rdata, wb_rdata, wb_alu;
   logic [4:0]  reg_rd, wb_rd;
   logic        memr, memw, regw, mem2r, zero, dm_req, dm_we, dm_ack, stall, pc_src, flush;
   logic        wb_regw, wb_mem2r, align_err, bus_err;
   logic [1:0]  branch;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk_i(clk), .rst_i(rst), .alu_c_i(alu_c), .rt_data_i(rt_data), .npc_i(npc),
      .reg_rd_i(reg_rd), .memr_i(memr), .memw_i(memw), .regw_i(regw), .mem2r_i(mem2r),
      .zero_i(zero), .branch_i(branch), .dm_req_o(dm_req), .dm_we_o(dm_we),
      .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata), .dm_rdata_i(dm_rdata), .dm_ack_i(dm_ack),
      .stall_o(stall), .pc_src_o(pc_src), .flush_o(flush), .wb_rdata_o(wb_rdata),
      .wb_alu_o(wb_alu), .wb_rd_o(wb_rd), .wb_regw_o(wb_regw), .wb_mem2r_o(wb_mem2r),
      .align_err_o(align_err), .bus_err_o(bus_err)
   );

   typedef struct {
      logic [31:0] alu_c;
      logic [31:0] rt;
      logic [4:0]  rd;
      logic        memr, memw, regw, mem2r, zero;
      logic [1:0]  br;
   } instr_t;

   int n_run  = 0;
   int n_fail = 0;

   // Reference state: last captured load data, MEM/WB contents, sticky flags.
   logic [31:0] m_cap, m_wb_alu, m_wb_rdata;
   logic [4:0]  m_wb_rd;
   logic        m_align, m_bus;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic apply(input instr_t i);
      alu_c = i.alu_c; rt_data = i.rt; reg_rd = i.rd; memr = i.memr; memw = i.memw;
      regw = i.regw; mem2r = i.mem2r; zero = i.zero; branch = i.br; npc = $urandom();
   endtask

   task automatic model_reset();
      m_cap = 0; m_wb_alu = 0; m_wb_rdata = 0; m_wb_rd = 0; m_align = 0; m_bus = 0;
   endtask

   task automatic check_wb(input string tag, input logic exp_regw, input logic exp_mem2r);
      chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(m_wb_rd));
      chk({tag, ".wb_alu"}, wb_alu, m_wb_alu);
      chk({tag, ".wb_rdata"}, wb_rdata, m_wb_rdata);
      chk({tag, ".wb_regw"}, 32'(wb_regw), 32'(exp_regw));
      chk({tag, ".wb_mem2r"}, 32'(wb_mem2r), 32'(exp_mem2r));
      chk({tag, ".align_err"}, 32'(align_err), 32'(m_align));
      chk({tag, ".bus_err"}, 32'(bus_err), 32'(m_bus));
   endtask

   // Presents one instruction and follows it until it leaves MEM. delay = number of REQ
   // cycles before ack (0 = ack in the first REQ cycle); 15 or more never acks in time.
   task automatic run_instr(input string tag, input instr_t i, input int delay,
                            input logic [31:0] rdata, output int n_stall, output int n_req);
      logic taken, access, mis, acked;
      int   nreq_exp;
      taken  = (i.br == 2'b01 && i.zero) || (i.br == 2'b10 && !i.zero) || (i.br == 2'b11);
      access = (i.memr || i.memw) && (i.alu_c[1:0] == 2'b00);
      mis    = (i.memr || i.memw) && (i.alu_c[1:0] != 2'b00);
      n_stall = 0; n_req = 0;
      apply(i);
      dm_ack = 1'($urandom_range(0, 1)); dm_rdata = $urandom();
      #2;
      if (stall) n_stall++;
      if (!access) begin
         chk({tag, ".stall"}, 32'(stall), 0);
         chk({tag, ".dm_req"}, 32'(dm_req), 0);
         chk({tag, ".pc_src"}, 32'(pc_src), 32'(taken));
         chk({tag, ".flush"}, 32'(flush), 32'(taken));
         @(posedge clk); #1;
         if (mis) m_align = 1;
         m_wb_rd = i.rd; m_wb_alu = i.alu_c; m_wb_rdata = m_cap;
         check_wb(tag, i.regw && !mis, i.mem2r);
      end else begin
         chk({tag, ".idle_stall"}, 32'(stall), 1);
         chk({tag, ".idle_pc_src"}, 32'(pc_src), 0);
         chk({tag, ".idle_dm_req"}, 32'(dm_req), 0);
         @(posedge clk); #1;
         acked    = (delay <= 14);
         nreq_exp = acked ? delay + 1 : 15;
         for (int k = 0; k < nreq_exp; k++) begin
            dm_ack   = acked && (k == delay);
            dm_rdata = dm_ack ? rdata : $urandom();
            #1;
            if (stall) n_stall++;
            if (dm_req) n_req++;
            chk({tag, ".req_dm_req"}, 32'(dm_req), 1);
            chk({tag, ".req_dm_we"}, 32'(dm_we), 32'(i.memw));
            chk({tag, ".req_dm_addr"}, dm_addr, i.alu_c);
            chk({tag, ".req_dm_wdata"}, dm_wdata, i.rt);
            chk({tag, ".req_stall"}, 32'(stall), 1);
            chk({tag, ".req_pc_src"}, 32'(pc_src), 0);
            chk({tag, ".req_wb_regw"}, 32'(wb_regw), 0);
            chk({tag, ".req_wb_alu_hold"}, wb_alu, m_wb_alu);
            @(posedge clk); #1;
         end
         m_cap = (acked && i.memr) ? rdata : 32'd0;
         if (!acked) m_bus = 1;
         // DONE: a stray ack here must not disturb the captured data.
         dm_ack = 1'($urandom_range(0, 1)); dm_rdata = $urandom();
         #1;
         chk({tag, ".done_stall"}, 32'(stall), 0);
         chk({tag, ".done_dm_req"}, 32'(dm_req), 0);
         chk({tag, ".done_dm_we"}, 32'(dm_we), 0);
         chk({tag, ".done_pc_src"}, 32'(pc_src), 32'(taken));
         chk({tag, ".done_wb_regw"}, 32'(wb_regw), 0);
         @(posedge clk); #1;
         m_wb_rd = i.rd; m_wb_alu = i.alu_c; m_wb_rdata = m_cap;
         check_wb(tag, i.regw, i.mem2r);
      end
      dm_ack = 0;
   endtask

   instr_t      ins;
   instr_t      nop;
   int          ns, nr;
   logic [31:0] a;

   initial begin
      nop = '{alu_c: 0, rt: 0, rd: 0, memr: 0, memw: 0, regw: 0, mem2r: 0, zero: 0, br: 0};
      rst = 1; apply(nop); dm_ack = 0; dm_rdata = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      model_reset();
      #1;
      chk("reset.dm_req", 32'(dm_req), 0);
      chk("reset.dm_we", 32'(dm_we), 0);
      chk("reset.dm_addr", dm_addr, 0);
      chk("reset.dm_wdata", dm_wdata, 0);
      chk("reset.stall", 32'(stall), 0);
      check_wb("reset", 1'b0, 1'b0);

      // Load, ack in second REQ cycle.
      ins = '{alu_c: 32'h100, rt: 32'h1234, rd: 5'd8, memr: 1, memw: 0, regw: 1, mem2r: 1,
              zero: 0, br: 2'b00};
      run_instr("load", ins, 1, 32'hDEADBEEF, ns, nr);
      chk("load.stall_cycles", ns, 3);
      chk("load.req_cycles", nr, 2);
      chk("load.wb_rdata_abs", wb_rdata, 32'hDEADBEEF);

      // Store, immediate ack.
      ins = '{alu_c: 32'h20, rt: 32'h5A5A5A5A, rd: 5'd3, memr: 0, memw: 1, regw: 0, mem2r: 0,
              zero: 1, br: 2'b00};
      run_instr("store", ins, 0, 32'hFFFF0000, ns, nr);
      chk("store.req_cycles", nr, 1);
      chk("store.wb_rdata_zero", wb_rdata, 0);

      // Load that is never acknowledged.
      ins = '{alu_c: 32'h40, rt: 0, rd: 5'd9, memr: 1, memw: 0, regw: 1, mem2r: 1,
              zero: 0, br: 2'b00};
      run_instr("timeout", ins, 255, 32'h0, ns, nr);
      chk("timeout.req_cycles", nr, 15);
      chk("timeout.bus_err", 32'(bus_err), 1);

      // Misaligned load.
      ins = '{alu_c: 32'h102, rt: 0, rd: 5'd4, memr: 1, memw: 0, regw: 1, mem2r: 1,
              zero: 0, br: 2'b00};
      run_instr("misaligned", ins, 0, 32'h0, ns, nr);
      chk("misaligned.align_err", 32'(align_err), 1);

      // Branch table.
      ins = nop; ins.alu_c = 32'h77; ins.regw = 1; ins.rd = 5'd1;
      ins.br = 2'b01; ins.zero = 1; run_instr("br01z1", ins, 0, 0, ns, nr);
      ins.br = 2'b10; ins.zero = 1; run_instr("br10z1", ins, 0, 0, ns, nr);
      ins.br = 2'b11; ins.zero = 0; run_instr("br11", ins, 0, 0, ns, nr);
      ins.br = 2'b00; ins.zero = 1; run_instr("br00", ins, 0, 0, ns, nr);
      ins.br = 2'b10; ins.zero = 0; run_instr("br10z0", ins, 0, 0, ns, nr);

      // Reset during the second REQ cycle, then a late ack.
      ins = '{alu_c: 32'h200, rt: 32'hAAAA5555, rd: 5'd7, memr: 1, memw: 0, regw: 1,
              mem2r: 1, zero: 0, br: 2'b00};
      apply(ins); dm_ack = 0;
      @(posedge clk); #1;
      chk("rstreq.req1", 32'(dm_req), 1);
      @(posedge clk); #1;
      chk("rstreq.req2", 32'(dm_req), 1);
      rst = 1; apply(nop);
      @(posedge clk); #1;
      rst = 0; dm_ack = 1; dm_rdata = 32'hCAFEF00D;
      model_reset();
      #1;
      chk("rstreq.dm_req", 32'(dm_req), 0);
      chk("rstreq.dm_addr", dm_addr, 0);
      chk("rstreq.dm_wdata", dm_wdata, 0);
      chk("rstreq.stall", 32'(stall), 0);
      check_wb("rstreq", 1'b0, 1'b0);
      @(posedge clk); #1;
      dm_ack = 0;
      chk("rstreq.late_dm_req", 32'(dm_req), 0);
      check_wb("rstreq_late", 1'b0, 1'b0);

      // Randomized instruction mix.
      for (int n = 0; n < 60; n++) begin
         int kind, dly;
         kind = $urandom_range(0, 3);
         a = $urandom();
         ins.rt = $urandom(); ins.rd = 5'($urandom()); ins.regw = 1'($urandom());
         ins.mem2r = 1'($urandom()); ins.zero = 1'($urandom()); ins.br = 2'($urandom());
         ins.memr = 0; ins.memw = 0;
         if (kind == 1) ins.memr = 1;
         if (kind == 2) ins.memw = 1;
         if (kind == 3) begin
            if ($urandom_range(0, 1) == 1) ins.memr = 1; else ins.memw = 1;
            a[1:0] = 2'($urandom_range(1, 3));
         end else if (kind != 0) begin
            a[1:0] = 2'b00;
         end
         ins.alu_c = a;
         case ($urandom_range(0, 6))
            0: dly = 14;
            1: dly = 15;
            2: dly = 255;
            default: dly = $urandom_range(0, 3);
         endcase
         run_instr("rand", ins, dly, $urandom(), ns, nr);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
